bcd_to_binary_seq: RTL and testbench

Sequential BCD-to-binary converter using reverse double dabble (shift-right, subtract-3). It converts a 5-digit packed BCD value into an unsigned binary value, resolving one bit per clock. It sits on the operand-entry side of the signed multiplier datapath, turning decimal digits from switches or keypad into binary operands. It is the inverse of the existing combinational binary-to-BCD display path, traded for area.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_to_binary_seq_if.sv | 15 +
 rtl/bcd_digit_sub3.sv | 12 +
 rtl/bcd_to_binary_seq.sv | 100 ++++++++++
 tb/tb_bcd_to_binary_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary conversion paths.
// The add-3 pair serves the binary-to-BCD display direction.
package bcd_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADD_THRESH = 4'd5;
    localparam logic [3:0] ADD_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle between the operand-entry source and the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  valid;
    logic                  err;
    logic [BIN_W-1:0]      binary;

    modport master (output start, bcd, input busy, valid, err, binary);
    modport slave  (input start, bcd, output busy, valid, err, binary);
endinterface

// File: rtl/bcd_digit_sub3.sv
// Per-digit correction for reverse double dabble: digits that reached 8 after a
// right shift had a carried-in half-ten and lose 3.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= ADJ_THRESH) ? (digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one result bit per clock via
// shift-right / subtract-3, with up-front rejection of non-decimal digits.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_to_binary_seq_if.slave    bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [BIN_W-1:0]   binary_reg;
    logic               err_reg;

    logic [BCD_W+BIN_W-1:0] cat_shift;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BIN_W-1:0]       bin_shift;
    logic [DIGITS-1:0]      digit_bad;
    logic                   any_bad;

    assign cat_shift = {bcd_reg, bin_reg} >> 1;
    assign bcd_shift = cat_shift[BCD_W+BIN_W-1:BIN_W];
    assign bin_shift = cat_shift[BIN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_sub3 u_sub3 (
                .digit    (bcd_shift[gi*DIGIT_W +: DIGIT_W]),
                .adjusted (bcd_adj[gi*DIGIT_W +: DIGIT_W])
            );
            assign digit_bad[gi] = (bus.bcd[gi*DIGIT_W +: DIGIT_W] > DIGIT_MAX);
        end
    endgenerate

    assign any_bad = |digit_bad;

    // Count holds the number of shifts already done; the edge on which it equals
    // BIN_W-1 performs the final shift and publishes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            binary_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        bcd_reg   <= bus.bcd;
                        bin_reg   <= '0;
                        count_reg <= '0;
                        if (any_bad) begin
                            err_reg    <= 1'b1;
                            binary_reg <= '0;
                            state_reg  <= DONE;
                        end else begin
                            err_reg    <= 1'b0;
                            state_reg  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg   <= bcd_adj;
                    bin_reg   <= bin_shift;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_COUNT) begin
                        binary_reg <= bin_shift;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_reg == SHIFT);
    assign bus.valid  = (state_reg == DONE);
    assign bus.err    = err_reg;
    assign bus.binary = binary_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, corner sequences and
// random legal operands, with a queue of expected results checked at each valid.
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 5;
    localparam int BIN_W  = 17;

    typedef struct {
        logic [19:0] bcd;
        logic [16:0] bin;
        logic        err;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        logic [16:0] bin;
        logic        err;
        int          cycle;
        int          busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   failures;
    int   done_cnt;
    int   target;
    int   busy_cnt;
    exp_t sb[$];
    vec_t tbl[11];

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Result monitor: every valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 binary=%0h", bus.binary);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn bcd=%05h binary=%0d err=%0d cycle=%0d busy_cycles=%0d",
                             e.bcd, bus.binary, bus.err, cycle, busy_cnt);
                    check("binary", longint'(bus.binary), longint'(e.bin));
                    check("err", longint'(bus.err), longint'(e.err));
                    check("valid_cycle", longint'(cycle), longint'(e.cycle));
                    check("busy_cycles", longint'(busy_cnt), longint'(e.busy));
                    if (!e.err) check("bcd_reg_zero", longint'(dut.bcd_reg), 0);
                end
                busy_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic push_exp(input logic [19:0] v, input logic [16:0] eb, input logic ee);
        exp_t e;
        e.bcd   = v;
        e.bin   = eb;
        e.err   = ee;
        e.cycle = cycle + (ee ? 0 : BIN_W);
        e.busy  = ee ? 0 : BIN_W;
        sb.push_back(e);
        target++;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt < target && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=%0d required=%0d", done_cnt, target);
            done_cnt = target;
            sb.delete();
        end
    endtask

    // Drives one request, then scrambles bcd to show capture is one-shot.
    task automatic convert(input logic [19:0] v, input logic [16:0] eb, input logic ee);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(posedge clk);
        #1;
        push_exp(v, eb, ee);
        bus.start = 1'b0;
        bus.bcd   = ~v;
        wait_done();
    endtask

    initial begin
        int t;
        int v;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        target   = 0;
        busy_cnt = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bcd   = '0;

        tbl[0]  = '{20'h00000, 17'd0,      1'b0};
        tbl[1]  = '{20'h16384, 17'h04000,  1'b0};
        tbl[2]  = '{20'h99999, 17'h1869F,  1'b0};
        tbl[3]  = '{20'h1A234, 17'd0,      1'b1};
        tbl[4]  = '{20'h00042, 17'd42,     1'b0};
        tbl[5]  = '{20'h00009, 17'd9,      1'b0};
        tbl[6]  = '{20'h00010, 17'd10,     1'b0};
        tbl[7]  = '{20'h65536, 17'h10000,  1'b0};
        tbl[8]  = '{20'h0000A, 17'd0,      1'b1};
        tbl[9]  = '{20'hF0000, 17'd0,      1'b1};
        tbl[10] = '{20'h10000, 17'd10000,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_valid", longint'(bus.valid), 0);
        check("reset_err", longint'(bus.err), 0);
        check("reset_binary", longint'(bus.binary), 0);
        check("reset_bcd_reg", longint'(dut.bcd_reg), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            convert(tbl[i].bcd, tbl[i].bin, tbl[i].err);
        end

        // Start held high through SHIFT while bcd toggles; then back-to-back accept.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 20'h00123;
        @(posedge clk);
        #1;
        push_exp(20'h00123, 17'd123, 1'b0);
        t = 0;
        while (!bus.valid && t < 40) begin
            bus.bcd = t[0] ? 20'h00123 : 20'h00999;
            @(posedge clk);
            #1;
            t++;
        end
        check("ignored_start_valid_seen", longint'(bus.valid), 1);
        bus.bcd = 20'h00999;
        @(posedge clk);
        @(posedge clk);
        #1;
        push_exp(20'h00999, 17'd999, 1'b0);
        check("back_to_back_busy", longint'(bus.busy), 1);
        bus.start = 1'b0;
        wait_done();

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 20'h00777;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", longint'(bus.busy), 0);
        check("midreset_valid", longint'(bus.valid), 0);
        check("midreset_err", longint'(bus.err), 0);
        check("midreset_binary", longint'(bus.binary), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        convert(20'h00255, 17'd255, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            v = int'($urandom_range(99999, 0));
            convert(to_bcd(v), 17'(v), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
